// File: rtl/key_press_arbiter_if.sv
//----------------------------------------------------------------------
// Module   : key_press_arbiter_if
// Brief    : Valid/ready key-event channel from the arbiter to its consumer.
// Revision : 1.0
//----------------------------------------------------------------------
`default_nettype none

interface key_press_arbiter_if;
  logic       keyValid;
  logic [1:0] keyCode;
  logic       keyReady;

  modport master (output keyValid, output keyCode, input keyReady);
  modport slave  (input keyValid, input keyCode, output keyReady);
endinterface

`default_nettype wire

// File: rtl/key_press_arbiter.sv
//----------------------------------------------------------------------
// Module   : key_press_arbiter
// Brief    : Sync + debounce of four active-low buttons, one event per press,
//            round-robin ordering, valid/ready output with backpressure.
// Revision : 1.0
//----------------------------------------------------------------------
`default_nettype none

module key_press_arbiter #(
  parameter int CLOCK_FREQ      = 50000000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 1000 * DEBOUNCE_MS
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic [3:0]        key,
  key_press_arbiter_if.master    keyBus,
  output logic      [3:0]        keyHeld,
  output logic                   overflow
);

  localparam int                 C_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] r_sync1, r_sync2;
  logic [3:0] w_stable;
  logic [3:0] r_stable_d;
  logic [3:0] r_press;
  logic [3:0] r_pending;
  logic [1:0] r_rr;
  logic       r_valid;
  logic [1:0] r_code;
  logic       r_overflow;

  logic       w_grant;
  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic [3:0] w_gmask;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_st;

    // Stable level follows the synchronised key only after DEBOUNCE_CYCLES disagreeing cycles.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
        r_st  <= 1'b1;
      end else if (r_sync2[gi] == r_st) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_MAX) begin
        r_st  <= r_sync2[gi];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_stable[gi] = r_st;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stable_d <= 4'hF;
      r_press    <= 4'h0;
    end else begin
      r_stable_d <= w_stable;
      r_press    <= r_stable_d & ~w_stable;
    end
  end

  // Round-robin search starting at r_rr; first pending key wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_rr + 2'(k);
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_grant = (|r_pending) && (!r_valid || keyBus.keyReady);
  assign w_gmask = w_grant ? (4'b0001 << w_win) : 4'b0000;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending  <= 4'h0;
      r_overflow <= 1'b0;
      r_rr       <= 2'd0;
      r_valid    <= 1'b0;
      r_code     <= 2'd0;
    end else begin
      // A press landing on a slot granted this cycle re-arms it instead of overflowing.
      r_pending  <= (r_pending & ~w_gmask) | r_press;
      r_overflow <= |(r_press & r_pending & ~w_gmask);
      if (w_grant) begin
        r_valid <= 1'b1;
        r_code  <= w_win;
        r_rr    <= w_win + 2'd1;
      end else if (r_valid && keyBus.keyReady) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign keyBus.keyValid = r_valid;
  assign keyBus.keyCode  = r_code;
  assign keyHeld         = ~r_stable_d;
  assign overflow        = r_overflow;

endmodule

`default_nettype wire
